// File: rtl/pipeline_stall_controller_pkg.sv
// Shared ISA decode constants and FSM encodings for the pipeline stall controller.
// Holds opcode / ALU-op values, instruction field extractors and the state codes
// used by the top-level FSM.
package pipeline_stall_controller_pkg;

  // Opcodes (instr[31:27])
  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_J     = 5'd1;
  localparam logic [4:0] OP_BNE   = 5'd2;
  localparam logic [4:0] OP_JAL   = 5'd3;
  localparam logic [4:0] OP_JR    = 5'd4;
  localparam logic [4:0] OP_ADDI  = 5'd5;
  localparam logic [4:0] OP_BLT   = 5'd6;
  localparam logic [4:0] OP_SW    = 5'd7;
  localparam logic [4:0] OP_LW    = 5'd8;
  localparam logic [4:0] OP_SETX  = 5'd21;
  localparam logic [4:0] OP_BEX   = 5'd22;

  // ALU ops (instr[6:2]) that go to the multdiv unit
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  // bex tests rstatus
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [4:0] f_opcode(input logic [31:0] instr);
    return instr[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] instr);
    return instr[6:2];
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector.
// Flags when a lw in DX writes a non-zero register that the instruction in FD reads.
// Ports:
//   FD_Latch_Instr  in   instruction currently in the FD latch
//   DX_Latch_Instr  in   instruction currently in the DX latch
//   load_use        out  1 when FD must wait one cycle for the load data
module load_use_detector
  import pipeline_stall_controller_pkg::*;
(
  input  logic [31:0] FD_Latch_Instr,
  input  logic [31:0] DX_Latch_Instr,
  output logic        load_use
);

  logic [4:0] dx_rd;
  logic [4:0] fd_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic       fd_reads_dx_rd;

  assign dx_rd = f_rd(DX_Latch_Instr);
  assign fd_rd = f_rd(FD_Latch_Instr);
  assign fd_rs = f_rs(FD_Latch_Instr);
  assign fd_rt = f_rt(FD_Latch_Instr);

  // Source registers depend on the FD instruction format; branches read rd as a source.
  always_comb begin
    fd_reads_dx_rd = 1'b0;
    case (f_opcode(FD_Latch_Instr))
      OP_RTYPE:              fd_reads_dx_rd = (fd_rs == dx_rd) || (fd_rt == dx_rd);
      OP_ADDI, OP_LW, OP_SW: fd_reads_dx_rd = (fd_rs == dx_rd);
      OP_BNE, OP_BLT:        fd_reads_dx_rd = (fd_rd == dx_rd) || (fd_rs == dx_rd);
      OP_JR:                 fd_reads_dx_rd = (fd_rd == dx_rd);
      OP_BEX:                fd_reads_dx_rd = (dx_rd == REG_RSTATUS);
      default:               fd_reads_dx_rd = 1'b0;
    endcase
  end

  assign load_use = (f_opcode(DX_Latch_Instr) == OP_LW) && (dx_rd != 5'd0) && fd_reads_dx_rd;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall / flush controller for the 5-stage processor.
// Resolves load-use stalls, multi-cycle mul/div holds (with a watchdog) and taken-branch
// squashes, driving latch enables, nop inserts and the multdiv start pulses.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   FD_Latch_Instr/DX_Latch_Instr instructions in the FD and DX latches
//   branch_taken                  execute stage resolved a taken control transfer
//   multdiv_resultRDY/_exception  multdiv completion pulse and its exception flag
//   PC/FD/DX enables, FD/DX/XM nop inserts, ctrl_MULT/ctrl_DIV start pulses,
//   multdiv_result_select, multdiv_exception_out, multdiv_busy
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MD_MAX_CYCLES = 40,
  parameter int unsigned MD_CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_Latch_Instr,
  input  logic [31:0] DX_Latch_Instr,
  input  logic        branch_taken,
  input  logic        multdiv_resultRDY,
  input  logic        multdiv_exception,
  output logic        PC_enable,
  output logic        FD_Latch_enable,
  output logic        DX_Latch_enable,
  output logic        FD_insert_nop,
  output logic        DX_insert_nop,
  output logic        XM_insert_nop,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        multdiv_result_select,
  output logic        multdiv_exception_out,
  output logic        multdiv_busy
);

  logic [1:0]          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                exc_q, exc_d;
  logic                dx_is_md;
  logic                load_use;

  load_use_detector u_load_use_detector (
    .FD_Latch_Instr (FD_Latch_Instr),
    .DX_Latch_Instr (DX_Latch_Instr),
    .load_use       (load_use)
  );

  assign dx_is_md = (f_opcode(DX_Latch_Instr) == OP_RTYPE) &&
                    ((f_aluop(DX_Latch_Instr) == ALU_MUL) || (f_aluop(DX_Latch_Instr) == ALU_DIV));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    case (state_q)
      ST_IDLE: begin
        // A resultRDY seen here belongs to nothing in flight and is dropped.
        if (dx_is_md) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (multdiv_resultRDY) begin
          state_d = ST_DONE;
          exc_d   = multdiv_exception;
        end else if (cnt_q == MD_CNT_W'(MD_MAX_CYCLES - 1)) begin
          // Watchdog: unit never answered, complete with an exception.
          state_d = ST_DONE;
          exc_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    PC_enable             = 1'b1;
    FD_Latch_enable       = 1'b1;
    DX_Latch_enable       = 1'b1;
    FD_insert_nop         = 1'b0;
    DX_insert_nop         = 1'b0;
    XM_insert_nop         = 1'b0;
    ctrl_MULT             = 1'b0;
    ctrl_DIV              = 1'b0;
    multdiv_result_select = 1'b0;
    multdiv_exception_out = 1'b0;
    multdiv_busy          = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (dx_is_md) begin
            ctrl_MULT       = (f_aluop(DX_Latch_Instr) == ALU_MUL);
            ctrl_DIV        = (f_aluop(DX_Latch_Instr) == ALU_DIV);
            PC_enable       = 1'b0;
            FD_Latch_enable = 1'b0;
            DX_Latch_enable = 1'b0;
            XM_insert_nop   = 1'b1;
            multdiv_busy    = 1'b1;
          end else if (branch_taken) begin
            // Squash wrong path; also covers a load-use consumer, which is discarded.
            FD_insert_nop = 1'b1;
            DX_insert_nop = 1'b1;
          end else if (load_use) begin
            PC_enable       = 1'b0;
            FD_Latch_enable = 1'b0;
            DX_insert_nop   = 1'b1;
          end
        end
        ST_BUSY: begin
          PC_enable       = 1'b0;
          FD_Latch_enable = 1'b0;
          DX_Latch_enable = 1'b0;
          XM_insert_nop   = 1'b1;
          multdiv_busy    = 1'b1;
        end
        ST_DONE: begin
          multdiv_result_select = 1'b1;
          multdiv_exception_out = exc_q;
          multdiv_busy          = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a behavioural model predicts the
// per-cycle output vector, a monitor compares it against the DUT on the falling edge.
module tb_pipeline_stall_controller;

  localparam int MD_MAX = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] FD_Latch_Instr, DX_Latch_Instr;
  logic        branch_taken, multdiv_resultRDY, multdiv_exception;
  logic        PC_enable, FD_Latch_enable, DX_Latch_enable;
  logic        FD_insert_nop, DX_insert_nop, XM_insert_nop;
  logic        ctrl_MULT, ctrl_DIV, multdiv_result_select, multdiv_exception_out, multdiv_busy;

  pipeline_stall_controller #(
    .MD_MAX_CYCLES (40),
    .MD_CNT_W      (6)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .FD_Latch_Instr        (FD_Latch_Instr),
    .DX_Latch_Instr        (DX_Latch_Instr),
    .branch_taken          (branch_taken),
    .multdiv_resultRDY     (multdiv_resultRDY),
    .multdiv_exception     (multdiv_exception),
    .PC_enable             (PC_enable),
    .FD_Latch_enable       (FD_Latch_enable),
    .DX_Latch_enable       (DX_Latch_enable),
    .FD_insert_nop         (FD_insert_nop),
    .DX_insert_nop         (DX_insert_nop),
    .XM_insert_nop         (XM_insert_nop),
    .ctrl_MULT             (ctrl_MULT),
    .ctrl_DIV              (ctrl_DIV),
    .multdiv_result_select (multdiv_result_select),
    .multdiv_exception_out (multdiv_exception_out),
    .multdiv_busy          (multdiv_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [10:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [10:0] act;
  assign act = {PC_enable, FD_Latch_enable, DX_Latch_enable, FD_insert_nop, DX_insert_nop,
                XM_insert_nop, ctrl_MULT, ctrl_DIV, multdiv_result_select,
                multdiv_exception_out, multdiv_busy};

  // Model state: is a mul/div outstanding, how long, and is the one-cycle completion due.
  bit m_busy = 0;
  bit m_done = 0;
  bit m_exc  = 0;
  int m_cycles = 0;

  function automatic logic [31:0] mk(int op, int rd, int rs, int rt, int alu);
    logic [31:0] w;
    w = '0;
    w[31:27] = op[4:0];
    w[26:22] = rd[4:0];
    w[21:17] = rs[4:0];
    w[16:12] = rt[4:0];
    w[6:2]   = alu[4:0];
    return w;
  endfunction

  // Registers the FD instruction consumes, listed by format.
  function automatic bit fd_reads(logic [31:0] fd, int r);
    int srcs[$];
    int op;
    op = int'(fd[31:27]);
    case (op)
      0:       begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[16:12])); end
      5, 7, 8: srcs.push_back(int'(fd[21:17]));
      2, 6:    begin srcs.push_back(int'(fd[26:22])); srcs.push_back(int'(fd[21:17])); end
      4:       srcs.push_back(int'(fd[26:22]));
      22:      srcs.push_back(30);
      default: ;
    endcase
    foreach (srcs[i]) if (srcs[i] == r) return 1;
    return 0;
  endfunction

  task automatic step(input logic [31:0] fd, input logic [31:0] dx, input bit br, input bit rdy,
                      input bit exc, input bit rst);
    bit pc, fde, dxe, fdn, dxn, xmn, mu, dv, sel, eo, bsy;
    bit is_md, lu;
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    FD_Latch_Instr = fd;
    DX_Latch_Instr = dx;
    branch_taken = br;
    multdiv_resultRDY = rdy;
    multdiv_exception = exc;
    reset = rst;
    {pc, fde, dxe} = 3'b111;
    {fdn, dxn, xmn, mu, dv, sel, eo, bsy} = '0;
    is_md = (dx[31:27] == 0) && (dx[6:2] == 6 || dx[6:2] == 7);
    lu = (dx[31:27] == 8) && (dx[26:22] != 0) && fd_reads(fd, int'(dx[26:22]));
    if (rst) begin
      m_busy = 0; m_done = 0; m_cycles = 0;
    end else if (m_done) begin
      sel = 1; eo = m_exc; bsy = 1;
      m_done = 0;
    end else if (m_busy) begin
      {pc, fde, dxe} = 3'b000; xmn = 1; bsy = 1;
      m_cycles++;
      if (rdy) begin
        m_busy = 0; m_done = 1; m_exc = exc;
      end else if (m_cycles == MD_MAX) begin
        m_busy = 0; m_done = 1; m_exc = 1;
      end
    end else if (is_md) begin
      mu = (dx[6:2] == 6); dv = (dx[6:2] == 7);
      {pc, fde, dxe} = 3'b000; xmn = 1; bsy = 1;
      m_busy = 1; m_cycles = 0;
    end else if (br) begin
      fdn = 1; dxn = 1;
    end else if (lu) begin
      pc = 0; fde = 0; dxn = 1;
    end
    e.cyc = cyc;
    e.v = {pc, fde, dxe, fdn, dxn, xmn, mu, dv, sel, eo, bsy};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL outputs cyc %0d: got %b required %b", e.cyc, act, e.v);
        end
      end
    end
  end

  logic [31:0] nop_i, lw5, lw0, add_dep, add_r0, mul_i, div_i;
  int ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};

  function automatic int rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_instr(bit lw_bias);
    int op;
    op = (lw_bias && $urandom_range(0, 2) == 0) ? 8 : ops[$urandom_range(0, 10)];
    return mk(op, rnd_reg(), rnd_reg(), rnd_reg(), int'($urandom_range(0, 7)));
  endfunction

  initial begin : stim
    nop_i   = '0;
    lw5     = mk(8, 5, 1, 0, 0);
    lw0     = mk(8, 0, 1, 0, 0);
    add_dep = mk(0, 1, 5, 2, 0);
    add_r0  = mk(0, 1, 0, 2, 0);
    mul_i   = mk(0, 3, 1, 2, 6);
    div_i   = mk(0, 3, 1, 2, 7);
    reset = 1; FD_Latch_Instr = '0; DX_Latch_Instr = '0;
    branch_taken = 0; multdiv_resultRDY = 0; multdiv_exception = 0;

    repeat (3) step(nop_i, nop_i, 0, 0, 0, 1);
    // Load-use stall, then lw r0 (no stall), then branch overriding load-use.
    step(add_dep, lw5, 0, 0, 0, 0);
    step(nop_i, nop_i, 0, 0, 0, 0);
    step(add_r0, lw0, 0, 0, 0, 0);
    step(add_dep, lw5, 1, 0, 0, 0);
    // mul with RDY 17 cycles after the pulse.
    step(nop_i, mul_i, 0, 0, 0, 0);
    repeat (16) step(nop_i, mul_i, 0, 0, 0, 0);
    step(nop_i, mul_i, 0, 1, 0, 0);
    step(nop_i, mul_i, 0, 0, 0, 0);
    step(nop_i, nop_i, 0, 0, 0, 0);
    // div with exception, followed directly by a second div.
    step(nop_i, div_i, 0, 1, 0, 0);
    repeat (2) step(nop_i, div_i, 0, 0, 0, 0);
    step(nop_i, div_i, 0, 1, 1, 0);
    step(nop_i, div_i, 0, 0, 0, 0);
    step(nop_i, div_i, 0, 0, 0, 0);
    step(nop_i, div_i, 0, 1, 0, 0);
    step(nop_i, div_i, 0, 0, 0, 0);
    step(nop_i, nop_i, 0, 0, 0, 0);
    // Watchdog: no RDY at all.
    step(nop_i, mul_i, 0, 0, 0, 0);
    repeat (MD_MAX) step(nop_i, mul_i, 0, 0, 0, 0);
    step(nop_i, mul_i, 0, 0, 0, 0);
    step(nop_i, nop_i, 0, 0, 0, 0);
    // Reset on the fifth BUSY cycle, then a late RDY.
    step(nop_i, div_i, 0, 0, 0, 0);
    repeat (4) step(nop_i, div_i, 0, 0, 0, 0);
    step(nop_i, div_i, 0, 0, 0, 1);
    step(nop_i, nop_i, 0, 1, 1, 0);
    step(add_dep, lw5, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(rnd_instr(0), rnd_instr(1), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 249) == 0));
    end

    repeat (4) @(posedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Owns every pipeline stall and flush decision in the 5-stage processor. It complements the combinational bypass selects, which handle all forwardable hazards.
- Covers three cases that bypassing cannot resolve:
  - load-use: lw in DX, consumer in FD;
  - multi-cycle mul/div: holds the pipe while the multdiv unit runs;
  - taken branch/jump: squashes the wrong-path instructions in FD and DX.
- Sits beside the FD/DX/XM latches and drives their enables and nop-insert controls, plus the multdiv start pulses.

Parameters:
MD_MAX_CYCLES, 40, watchdog limit on BUSY cycles before a forced completion with exception
MD_CNT_W, 6, width of the watchdog counter; must satisfy 2^MD_CNT_W > MD_MAX_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
FD_Latch_Instr  in  32  instruction in FD latch
DX_Latch_Instr  in  32  instruction in DX latch
branch_taken  in  1  execute stage resolved taken bne/blt/j/jal/jr/bex this cycle
multdiv_resultRDY  in  1  multdiv result valid (pulse)
multdiv_exception  in  1  multdiv exception, qualified by resultRDY
PC_enable  out  1  PC register write enable
FD_Latch_enable  out  1  FD latch write enable
DX_Latch_enable  out  1  DX latch write enable
FD_insert_nop  out  1  FD latch loads 32'd0 next edge
DX_insert_nop  out  1  DX latch loads 32'd0 next edge
XM_insert_nop  out  1  XM latch loads 32'd0 next edge
ctrl_MULT  out  1  one-cycle multdiv start, multiply
ctrl_DIV  out  1  one-cycle multdiv start, divide
multdiv_result_select  out  1  XM ALU-result mux takes the multdiv result
multdiv_exception_out  out  1  XM latch records exception (rstatus write)
multdiv_busy  out  1  high in START/BUSY/DONE

Behaviour:
- Field decode: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Opcodes: R-type 0, j 1, bne 2, jal 3, jr 4, addi 5, sw 7, lw 8, setx 21, bex 22. ALU op: mul 6, div 7.
- DX_is_md = DX opcode 0 and ALU op 6 or 7.
- FSM states: IDLE, BUSY, DONE. The watchdog counter cnt is MD_CNT_W bits.
- Reset (sampled on clock edge), including mid-operation:
  - state becomes IDLE and cnt becomes 0;
  - while reset is high: all enables = 1, all nop-inserts = 0, ctrl_MULT/ctrl_DIV = 0, select = 0, exception_out = 0, busy = 0;
  - any in-flight multdiv result is discarded.
- IDLE, when DX_is_md:
  - ctrl_MULT (ALU op 6) or ctrl_DIV (ALU op 7) = 1 for this cycle only;
  - PC/FD/DX enables = 0, XM_insert_nop = 1;
  - next state BUSY, cnt becomes 0;
  - resultRDY in this cycle is ignored.
- IDLE, not md:
  - load_use = DX opcode 8 AND DX rd != 0 AND FD reads DX rd. FD read sets by FD opcode:
    - R-type: rs, rt
    - addi, lw, sw: rs
    - bne, blt: rd, rs
    - jr: rd
    - bex: r30
  - If load_use: PC_enable = 0, FD_Latch_enable = 0, DX_insert_nop = 1. The stall lasts one cycle; the next cycle re-evaluates.
  - If branch_taken: FD_insert_nop = 1 and DX_insert_nop = 1, with PC/FD enables = 1 so the PC loads the target. branch_taken has priority over load_use (the consumer is squashed).
  - Otherwise: all enables = 1, no nops.
- BUSY:
  - PC/FD/DX enables = 0, XM_insert_nop = 1, cnt increments.
  - resultRDY moves the state to DONE and registers multdiv_exception.
  - If cnt == MD_MAX_CYCLES-1 without RDY: move to DONE with the exception flag forced to 1.
  - branch_taken and load_use are ignored.
- DONE (exactly one cycle):
  - all enables = 1, multdiv_result_select = 1;
  - multdiv_exception_out = registered flag;
  - the mul/div leaves DX into XM;
  - no ctrl pulse even though DX still holds the mul/div;
  - next state IDLE.
- multdiv_busy = 1 in BUSY and DONE, and in IDLE when DX_is_md.
- Latency: from the ctrl pulse, the pipeline resumes 1 cycle after RDY is sampled. Minimum stall is 2 cycles (RDY on the first BUSY cycle).
- Back-to-back mul/div: the second is seen in IDLE on the cycle after DONE and gets a fresh pulse.

Decomposition:
- Shared include isa_defs.vh: opcode constants, ALU-op constants for mul/div, field bit positions, state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- Sub-module load_use_detector: combinational. Inputs FD_Latch_Instr and DX_Latch_Instr; output load_use.
- FSM, watchdog and output muxing stay in the top module.

Test Plan:
- Load-use: lw r5 in DX, add r1,r5,r2 in FD → one cycle of PC_enable = 0, FD_Latch_enable = 0, DX_insert_nop = 1, then all enables = 1. Repeat with lw r0: no stall.
- Branch flush: branch_taken = 1 with lw r5 in DX and a dependent add in FD → FD_insert_nop = DX_insert_nop = 1, PC_enable = 1, no load-use stall.
- mul (ALU op 6) in DX, RDY asserted 17 cycles after the pulse:
  - ctrl_MULT = 1 for exactly 1 cycle;
  - 17 cycles with PC/FD/DX enables = 0 and XM_insert_nop = 1;
  - then 1 DONE cycle with multdiv_result_select = 1;
  - ctrl_DIV never asserted.
- div with RDY = 1 and exception = 1 → multdiv_exception_out = 1 in the DONE cycle only. Two consecutive divs → two separate ctrl_DIV pulses.
- No RDY for 40 BUSY cycles → DONE on the 41st cycle after the pulse with multdiv_exception_out = 1, then IDLE.
- reset asserted on cycle 5 of BUSY → next cycle IDLE, all enables = 1, busy = 0; a late RDY is ignored.
